// File: rtl/viterbi_output_packer.sv
// viterbi_output_packer: packs the 1-bit decoded stream from dec_viterbi into
// DATA_W-bit words, LSB first. Each word carries a valid-bit count (tuser)
// and a frame-end marker (tlast).
// Optional build macro VITERBI_PACK_FRAME_CNT_EN adds a 16-bit frame_count
// output that counts output words handed off with tlast set.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no bits collected for the current word (bit_cnt == 0)
// FILL  | at least one bit collected, word not yet complete
module viterbi_output_packer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic [CNT_W-1:0]  m_axis_tuser,
`ifdef VITERBI_PACK_FRAME_CNT_EN
    output logic [15:0]       frame_count,
`endif
    input  logic              m_axis_tready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] acc_with_bit;
    logic              accept;
    logic              complete;
    logic              out_hs;

    // The output register can take a new word when it is empty or draining this cycle.
    always_comb begin
        s_axis_tready = !m_axis_tvalid || m_axis_tready;
        accept        = s_axis_tvalid && s_axis_tready;
        complete      = accept && ((bit_cnt == CNT_W'(DATA_W - 1)) || s_axis_tlast);
        out_hs        = m_axis_tvalid && m_axis_tready;
        acc_with_bit  = acc | ({{(DATA_W-1){1'b0}}, s_axis_tdata} << bit_cnt);
    end

    // Next state: a completing bit always returns to EMPTY, including 1-bit frames.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept && !complete) state_next = FILL;
            FILL:  if (complete)            state_next = EMPTY;
            default:                        state_next = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= EMPTY;
        else          state <= state_next;
    end

    // Accumulator and bit position; both clear when a word completes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (complete) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            acc     <= acc_with_bit;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Output register: reload on completion (even while draining, so no bubble), else release on handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (complete) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= acc_with_bit;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tuser  <= bit_cnt + CNT_W'(1);
        end else if (out_hs) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef VITERBI_PACK_FRAME_CNT_EN
    // Completed-frame counter; wraps naturally at 16 bits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                   frame_count <= '0;
        else if (out_hs && m_axis_tlast) frame_count <= frame_count + 16'd1;
    end
`endif

endmodule
